// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch arbiter.
// Optional horizontal mirroring is enabled with SPRITE_FLIP_EN.
package sprite_pkg;

  localparam int SPRITE_W_DEF = 32;
  localparam int SPRITE_H_DEF = 48;

  localparam int FB_BASE = 0;
  localparam int IG_BASE = SPRITE_W_DEF * SPRITE_H_DEF;

  localparam logic [7:0] TRANSPARENT_IDX = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_F,
    FETCH_I,
    RESOLVE
  } arb_state_t;

  typedef struct packed {
    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] fb_x;
    logic [9:0] fb_y;
    logic [9:0] ig_x;
    logic [9:0] ig_y;
    logic       fb_flip;
    logic       ig_flip;
  } pix_req_t;

endpackage

// File: rtl/sprite_box_check.sv
// Bounding-box test and sprite ROM address for one character.
// Mirroring (SPRITE_FLIP_EN) reflects the local x inside the box.
module sprite_box_check #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 48,
  parameter int ROM_AW   = 12
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [ROM_AW-1:0] base,
  input  logic              flip,
  output logic              in_box,
  output logic [ROM_AW-1:0] addr
);

  logic [10:0] x11, y11, px11, py11;
  logic [10:0] lx, ly;

  always_comb begin
    x11  = {1'b0, draw_x};
    y11  = {1'b0, draw_y};
    px11 = {1'b0, pos_x};
    py11 = {1'b0, pos_y};
    // 11-bit sums keep a box near 1023 from aliasing to low coords
    in_box = (x11 >= px11) &&
             (x11 < px11 + 11'(SPRITE_W)) &&
             (y11 >= py11) &&
             (y11 < py11 + 11'(SPRITE_H));
    lx = x11 - px11;
    ly = y11 - py11;
`ifdef SPRITE_FLIP_EN
    if (flip) lx = 11'(SPRITE_W - 1) - lx;
`endif
    addr = base;
    if (in_box)
      addr = ROM_AW'(32'(base) +
                     32'(ly) * 32'(SPRITE_W) +
                     32'(lx));
  end

`ifndef SPRITE_FLIP_EN
  logic unused_flip;
  assign unused_flip = flip;
`endif

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Time-multiplexes one sprite ROM between fireboy and icegirl per pixel.
// Build with SPRITE_FLIP_EN to honour fb_flip/ig_flip.
module sprite_fetch_arbiter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int ROM_AW   = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        fb_x,
  input  logic [9:0]        fb_y,
  input  logic [9:0]        ig_x,
  input  logic [9:0]        ig_y,
  input  logic              fb_flip,
  input  logic              ig_flip,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              sprite_valid,
  output logic              sprite_hit,
  output logic [7:0]        sprite_data,
  output logic              overrun
);

  localparam logic [ROM_AW-1:0] FB_A =
    ROM_AW'(FB_BASE);
  localparam logic [ROM_AW-1:0] IG_A =
    ROM_AW'(SPRITE_W * SPRITE_H);

  arb_state_t        state_q, state_d;
  pix_req_t          req_q, req_d, req_in;
  logic [7:0]        fb_px_q, fb_px_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              valid_q, valid_d;
  logic              hit_q, hit_d;
  logic [7:0]        data_q, data_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              fb_in, ig_in;
  logic [ROM_AW-1:0] fb_addr, ig_addr;
  logic [7:0]        ig_px;

  assign req_in = '{
    dx:      DrawX,
    dy:      DrawY,
    fb_x:    fb_x,
    fb_y:    fb_y,
    ig_x:    ig_x,
    ig_y:    ig_y,
    fb_flip: fb_flip,
    ig_flip: ig_flip
  };

  assign accept = pixel_start &&
                  (state_q == IDLE ||
                   state_q == RESOLVE);

  // Fireboy looks at the next request so its address
  // can be registered on the accepting edge.
  sprite_box_check #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .ROM_AW  (ROM_AW)
  ) u_fb (
    .draw_x(req_d.dx),
    .draw_y(req_d.dy),
    .pos_x (req_d.fb_x),
    .pos_y (req_d.fb_y),
    .base  (FB_A),
    .flip  (req_d.fb_flip),
    .in_box(fb_in),
    .addr  (fb_addr)
  );

  sprite_box_check #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .ROM_AW  (ROM_AW)
  ) u_ig (
    .draw_x(req_q.dx),
    .draw_y(req_q.dy),
    .pos_x (req_q.ig_x),
    .pos_y (req_q.ig_y),
    .base  (IG_A),
    .flip  (req_q.ig_flip),
    .in_box(ig_in),
    .addr  (ig_addr)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    fb_px_d    = fb_px_q;
    rom_addr_d = rom_addr_q;
    valid_d    = 1'b0;
    hit_d      = hit_q;
    data_d     = data_q;
    overrun_d  = overrun_q;
    ig_px      = ig_in ? rom_data : TRANSPARENT_IDX;

    if (accept) req_d = req_in;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rom_addr_d = fb_addr;
          state_d    = FETCH_F;
        end
      end
      FETCH_F: begin
        rom_addr_d = ig_addr;
        state_d    = FETCH_I;
        if (pixel_start) overrun_d = 1'b1;
      end
      FETCH_I: begin
        fb_px_d = fb_in ? rom_data : TRANSPARENT_IDX;
        state_d = RESOLVE;
        if (pixel_start) overrun_d = 1'b1;
      end
      RESOLVE: begin
        valid_d = 1'b1;
        if (ig_px != TRANSPARENT_IDX) begin
          hit_d  = 1'b1;
          data_d = ig_px;
        end else if (fb_px_q != TRANSPARENT_IDX) begin
          hit_d  = 1'b1;
          data_d = fb_px_q;
        end else begin
          hit_d  = 1'b0;
          data_d = TRANSPARENT_IDX;
        end
        if (accept) begin
          rom_addr_d = fb_addr;
          state_d    = FETCH_F;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      fb_px_q    <= TRANSPARENT_IDX;
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      hit_q      <= 1'b0;
      data_q     <= TRANSPARENT_IDX;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fb_px_q    <= fb_px_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      hit_q      <= hit_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sprite_valid = valid_q;
  assign sprite_hit   = hit_q;
  assign sprite_data  = data_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Randomized bench with a behavioural pixel model for sprite_fetch_arbiter.
// Also pins the model with hand-computed directed pixels.
module tb_sprite_fetch_arbiter;

  localparam int W  = 32;
  localparam int H  = 48;
  localparam int AW = 12;
  localparam int IG_B = W * H;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          pixel_start = 1'b0;
  logic [9:0]    DrawX = '0, DrawY = '0;
  logic [9:0]    fb_x = '0, fb_y = '0;
  logic [9:0]    ig_x = '0, ig_y = '0;
  logic          fb_flip = 1'b0, ig_flip = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = '0;
  logic          sprite_valid, sprite_hit;
  logic [7:0]    sprite_data;
  logic          overrun;

  logic [7:0] mem [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  sprite_fetch_arbiter #(
    .SPRITE_W(W), .SPRITE_H(H), .ROM_AW(AW)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .pixel_start(pixel_start),
    .DrawX(DrawX), .DrawY(DrawY),
    .fb_x(fb_x), .fb_y(fb_y),
    .ig_x(ig_x), .ig_y(ig_y),
    .fb_flip(fb_flip), .ig_flip(ig_flip),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sprite_valid(sprite_valid),
    .sprite_hit(sprite_hit),
    .sprite_data(sprite_data),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= mem[rom_addr];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic void look(
    input int dx, input int dy, input int px, input int py,
    input bit flip, input int base,
    output int addr, output int idx);
    bit inb;
    int lx;
    inb = dx >= px && dx < px + W && dy >= py && dy < py + H;
    lx = dx - px;
    if (FLIP_EN && flip) lx = W - 1 - lx;
    addr = inb ? (base + (dy - py) * W + lx) % 4096 : base;
    idx = inb ? int'(mem[addr]) : 0;
  endfunction

  typedef struct { int at; int val; } ev_t;
  typedef struct { int at; bit hit; int data; } res_t;

  ev_t  addr_q[$];
  res_t res_q[$];

  // Model: a request is taken unless one was taken 1 or 2 cycles ago.
  initial begin : cmp
    int cyc = 0;
    int last = -100;
    bit e_hit = 0;
    int e_data = 0;
    bit e_ovr = 0;
    bit e_val;
    int fa, fp, ia, ip;
    forever begin
      @(posedge Clk); #1;
      cyc++;
      if (Reset) begin
        addr_q.delete(); res_q.delete();
        last = -100; e_hit = 0; e_data = 0; e_ovr = 0;
        chk("rst_valid", sprite_valid, 0);
        chk("rst_hit", sprite_hit, 0);
        chk("rst_data", sprite_data, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_addr", rom_addr, 0);
      end else begin
        if (pixel_start) begin
          if (cyc - last >= 3) begin
            last = cyc;
            look(DrawX, DrawY, fb_x, fb_y, fb_flip, 0, fa, fp);
            look(DrawX, DrawY, ig_x, ig_y, ig_flip, IG_B, ia, ip);
            addr_q.push_back('{cyc, fa});
            addr_q.push_back('{cyc + 1, ia});
            if (ip != 0) res_q.push_back('{cyc + 3, 1, ip});
            else if (fp != 0) res_q.push_back('{cyc + 3, 1, fp});
            else res_q.push_back('{cyc + 3, 0, 0});
          end else begin
            e_ovr = 1;
          end
        end
        e_val = 0;
        if (res_q.size() > 0 && res_q[0].at == cyc) begin
          e_val = 1;
          e_hit = res_q[0].hit;
          e_data = res_q[0].data;
          void'(res_q.pop_front());
        end
        chk("m_valid", sprite_valid, e_val);
        chk("m_hit", sprite_hit, e_hit);
        chk("m_data", sprite_data, e_data);
        chk("m_ovr", overrun, e_ovr);
        if (addr_q.size() > 0 && addr_q[0].at == cyc) begin
          chk("m_addr", rom_addr, addr_q[0].val);
          void'(addr_q.pop_front());
        end
      end
    end
  end

  task automatic set_pix(input int dx, input int dy,
                         input int fx, input int fy,
                         input int ix, input int iy,
                         input bit ff, input bit igf);
    DrawX = 10'(dx); DrawY = 10'(dy);
    fb_x = 10'(fx); fb_y = 10'(fy);
    ig_x = 10'(ix); ig_y = 10'(iy);
    fb_flip = ff; ig_flip = igf;
  endtask

  task automatic run_pixel(input string nm,
                           input int dx, input int dy,
                           input int fx, input int fy,
                           input int ix, input int iy,
                           input bit ff, input int e_addr,
                           input bit e_hit, input int e_data);
    @(negedge Clk);
    set_pix(dx, dy, fx, fy, ix, iy, ff, 1'b0);
    pixel_start = 1'b1;
    @(posedge Clk); #1;
    chk({nm, "_addr"}, rom_addr, e_addr);
    @(negedge Clk);
    pixel_start = 1'b0;
    set_pix($urandom_range(0, 1023), $urandom_range(0, 1023),
            dx, dy, dx, dy, ~ff, 1'b1);
    @(posedge Clk); #1;
    chk({nm, "_igaddr"}, rom_addr, IG_B + 0 * e_addr +
        ((ix <= dx && dx < ix + W && iy <= dy && dy < iy + H) ?
         (dy - iy) * W + (dx - ix) : 0));
    repeat (2) @(posedge Clk); #1;
    chk({nm, "_valid"}, sprite_valid, 1);
    chk({nm, "_hit"}, sprite_hit, e_hit);
    chk({nm, "_data"}, sprite_data, e_data);
    @(posedge Clk); #1;
    chk({nm, "_pulse"}, sprite_valid, 0);
  endtask

  initial begin : drv
    for (int i = 0; i < 4096; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 :
               8'($urandom_range(1, 255));
    mem[330] = 8'h06;
    mem[0] = 8'h55;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    run_pixel("fb_only", 100, 200, 90, 190, 700, 600,
              0, 330, 1, 8'h06);

    mem[645] = 8'h07; mem[1876] = 8'h0A;
    run_pixel("ovl_ig", 300, 300, 295, 280, 280, 290,
              0, 645, 1, 8'h0A);
    mem[1876] = 8'h00;
    run_pixel("ovl_fb", 300, 300, 295, 280, 280, 290,
              0, 645, 1, 8'h07);
    mem[645] = 8'h00;
    run_pixel("ovl_none", 300, 300, 295, 280, 280, 290,
              0, 645, 0, 0);

    run_pixel("nowrap", 5, 10, 1020, 0, 700, 600,
              0, 0, 0, 0);
    mem[351] = 8'h33; mem[320] = 8'h44;
    run_pixel("x_edge_out", 132, 110, 100, 100, 700, 600,
              0, 0, 0, 0);
    run_pixel("x_edge_in", 131, 110, 100, 100, 700, 600,
              0, 351, 1, 8'h33);
    run_pixel("flip", 50, 60, 50, 50, 700, 600, 1,
              FLIP_EN ? 351 : 320, 1,
              FLIP_EN ? 8'h33 : 8'h44);
    chk("ovr_clear", overrun, 0);

    // start, dropped start, start accepted from RESOLVE
    @(negedge Clk);
    set_pix(100, 200, 90, 190, 700, 600, 0, 0);
    pixel_start = 1'b1;
    @(negedge Clk);
    @(negedge Clk); pixel_start = 1'b0;
    @(negedge Clk); pixel_start = 1'b1;
    @(posedge Clk); #1;
    chk("bb_valid0", sprite_valid, 1);
    chk("bb_data0", sprite_data, 8'h06);
    chk("bb_ovr", overrun, 1);
    @(negedge Clk); pixel_start = 1'b0;
    repeat (3) @(posedge Clk); #1;
    chk("bb_valid1", sprite_valid, 1);

    // reset while in FETCH_I
    @(negedge Clk);
    set_pix(300, 300, 295, 280, 280, 290, 0, 0);
    mem[645] = 8'h07;
    pixel_start = 1'b1;
    @(negedge Clk); pixel_start = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    #1;
    chk("arst_ovr", overrun, 0);
    chk("arst_hit", sprite_hit, 0);
    chk("arst_data", sprite_data, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("arst_novalid", sprite_valid, 0);
    end
    run_pixel("post_rst", 100, 200, 90, 190, 700, 600,
              0, 330, 1, 8'h06);

    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      pixel_start = ($urandom_range(0, 2) == 0);
      DrawX = 10'($urandom_range(0, 1023));
      DrawY = 10'($urandom_range(0, 1023));
      fb_x = DrawX - 10'($urandom_range(0, 40)) + 10'd4;
      fb_y = DrawY - 10'($urandom_range(0, 56)) + 10'd4;
      ig_x = DrawX - 10'($urandom_range(0, 40)) + 10'd4;
      ig_y = DrawY - 10'($urandom_range(0, 56)) + 10'd4;
      fb_flip = 1'($urandom_range(0, 1));
      ig_flip = 1'($urandom_range(0, 1));
    end
    @(negedge Clk); pixel_start = 1'b0;
    repeat (6) @(posedge Clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

- Per-pixel scheduler that shares the single-port sprite ROM between the two characters, fireboy and icegirl.
- For each pixel request it:
  - tests both character bounding boxes;
  - issues two ROM reads in a fixed slot order;
  - resolves overlap priority;
  - delivers one registered palette index plus a hit flag to the color mapper.
- Sits between the VGA controller / character position logic and the color mapper, replacing direct per-character ROM ports.

## Interface
Parameters:
- SPRITE_W, 32: sprite width in pixels.
- SPRITE_H, 48: sprite height in pixels.
- ROM_AW, 12: sprite ROM address width; must hold 2*SPRITE_W*SPRITE_H.

Ports:
- Clk  in  1  system clock; one clock domain.
- Reset  in  1  asynchronous, active-high reset.
- pixel_start  in  1  one-cycle pulse: sample DrawX/DrawY and begin a lookup.
- DrawX, DrawY  in  10 each  pixel coordinates.
- fb_x, fb_y, ig_x, ig_y  in  10 each  top-left corners of fireboy and icegirl.
- fb_flip, ig_flip  in  1 each  horizontal mirror request; see Configuration.
- rom_addr  out  ROM_AW  sprite ROM address.
- rom_data  in  8  ROM read data; valid 1 cycle after rom_addr.
- sprite_valid  out  1  one-cycle pulse: sprite_hit/sprite_data updated.
- sprite_hit  out  1  resolved pixel is a non-transparent sprite pixel.
- sprite_data  out  8  palette index; 0 when sprite_hit=0.
- overrun  out  1  sticky: a pixel_start was dropped.

## Operation
- States: IDLE, FETCH_F, FETCH_I, RESOLVE.
- IDLE:
  - pixel_start: latch DrawX, DrawY and all position/flip inputs; go to FETCH_F.
- FETCH_F:
  - rom_addr = fireboy address; go to FETCH_I.
- FETCH_I:
  - rom_addr = icegirl address;
  - capture rom_data as fb_px (forced to 0 if fireboy out of box);
  - go to RESOLVE.
- RESOLVE:
  - capture ig_px (forced to 0 if icegirl out of box);
  - register the result and pulse sprite_valid;
  - pixel_start this cycle: latch the new pixel, go to FETCH_F; otherwise go to IDLE.
- Priority:
  - ig_px != 0 → icegirl wins;
  - else fb_px != 0 → fireboy wins;
  - else sprite_hit=0, sprite_data=0.
  - Index 0 is transparent.
- In-box test, computed in 11-bit unsigned arithmetic (no wrap):
  - pos_x <= DrawX < pos_x+SPRITE_W and pos_y <= DrawY < pos_y+SPRITE_H.
  - Position near 1023 must not alias to low coordinates.
- Local coordinates:
  - lx = DrawX-pos_x, ly = DrawY-pos_y.
  - address = base + ly*SPRITE_W + lx, truncated to ROM_AW.
  - base: fireboy 0, icegirl SPRITE_W*SPRITE_H.
- Out-of-box requester: its slot still occupies a cycle; rom_addr = its base.
- Dropped requests:
  - pixel_start in FETCH_F or FETCH_I is ignored and sets overrun.
  - overrun clears only on Reset.
- Inputs are latched once per pixel; changes mid-lookup do not affect the pending result.

## Timing
- Reset values:
  - state IDLE; rom_addr 0;
  - sprite_valid, sprite_hit, overrun all 0; sprite_data 0.
- Reset asserted mid-lookup: in-flight pixel discarded, no sprite_valid.
- Latency: pixel_start at cycle n → sprite_valid at cycle n+3.
- Back-to-back throughput: one pixel per 3 cycles (pixel_start accepted in RESOLVE).
- All outputs registered; sprite_hit/sprite_data hold between sprite_valid pulses.

## Configuration
- Macro SPRITE_FLIP_EN.
- Defined:
  - when the latched flip bit is 1 for a requester, lx = SPRITE_W-1-(DrawX-pos_x);
  - the box test is unchanged.
- Undefined:
  - fb_flip/ig_flip are ports but ignored;
  - no mirror logic is synthesized.

## Structure
- Package sprite_pkg holds:
  - SPRITE_W/SPRITE_H defaults;
  - FB_BASE and IG_BASE;
  - TRANSPARENT_IDX = 8'h00;
  - state enum typedef arb_state_t.
- Sub-module sprite_box_check, instantiated twice (once per character):
  - inputs: latched coordinates, position, base, flip;
  - outputs: in_box and ROM address.

## Test plan
- Pixel (100,200), fireboy at (90,190), icegirl far away, ROM[0+10*32+10]=8'h06:
  - rom_addr = 330 then IG_BASE;
  - sprite_valid at n+3, sprite_hit=1, sprite_data=8'h06.
- Both boxes cover the pixel, fb_px=8'h07, ig_px=8'h0A → sprite_data=8'h0A.
  - Repeat with ig_px=0 → 8'h07.
  - Both 0 → sprite_hit=0, sprite_data=0.
- Fireboy at x=1020, DrawX=5:
  - out of box, no wrap hit, sprite_hit=0.
  - Also check DrawX=pos_x+SPRITE_W is out of box.
- pixel_start on cycles n, n+1, n+3:
  - n+1 dropped, overrun=1;
  - n+3 accepted from RESOLVE, valid at n+3 and n+6.
- Reset asserted in FETCH_I:
  - outputs zero, no sprite_valid afterwards, next pixel_start works normally.
- SPRITE_FLIP_EN defined, fb_flip=1, lx raw=0:
  - address uses lx=31.
  - Undefined build: the same stimulus uses lx=0.
